// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (core / DMA) arbiter in front of the 4-bank byte-wide data memory
//
// Optional feature macro: DMEM_ARB_DMA_EN
//   defined   : core + DMA ports with burst lock and core starvation counter
//   undefined : core-only pass-through, DMA outputs tied 0, no FSM/counters
//
// Ports:
//   clk_i, rst_ni                      clock (rising edge), async active-low reset
//   core_req_i/we_i/addr_i/be_i/wdata_i MEM-stage load/store request
//   core_gnt_o, core_stall_o           core accepted this cycle / pipeline stall
//   core_rvalid_o, core_rdata_o        core read response (1 cycle after grant)
//   dma_req_i/we_i/addr_i/be_i/wdata_i DMA/loader request
//   dma_last_i                         final beat of a DMA burst
//   dma_gnt_o, dma_rvalid_o, dma_rdata_o DMA grant and read response
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o  bank drive (combinational mux)
//   mem_rdata_i                        bank read data, 1 cycle after a read enable

module dmem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [3:0]        core_be_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_stall_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [3:0]        dma_be_i,
    input  logic [31:0]       dma_wdata_i,
    input  logic              dma_last_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [31:0]       dma_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    logic core_gnt;
    logic dma_gnt;
    logic rsp_valid;
    logic rsp_owner;   // 1 = DMA issued the read in flight

`ifdef DMEM_ARB_DMA_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int BC_W = $clog2(BURST_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [BC_W-1:0] LAST_BEAT  = BC_W'(BURST_MAX - 1);
    // With a one-beat burst limit the first DMA grant is already the last.
    localparam bit CAN_LOCK = (BURST_MAX > 1);

    typedef enum logic {S_CORE, S_DMA} state_t;

    state_t          state;
    logic [SC_W-1:0] starve_cnt;
    logic [BC_W-1:0] beat_cnt;

    // Zero-cycle arbitration; reset suppresses every grant so outputs read 0.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (rst_ni) begin
            if (state == S_DMA) begin
                dma_gnt  = dma_req_i;
                core_gnt = core_req_i & ~dma_req_i;   // fill DMA bubbles
            end else if (core_req_i && dma_req_i) begin
                if (starve_cnt < STARVE_MAX) begin
                    core_gnt = 1'b1;
                end else begin
                    dma_gnt = 1'b1;
                end
            end else begin
                core_gnt = core_req_i;
                dma_gnt  = dma_req_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_CORE;
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                S_CORE: begin
                    if (dma_gnt) begin
                        starve_cnt <= '0;
                        if (!dma_last_i && CAN_LOCK) begin
                            state    <= S_DMA;
                            beat_cnt <= BC_W'(1);
                        end
                    end else if (core_gnt && dma_req_i) begin
                        // Saturates naturally: at the limit the core loses to DMA.
                        starve_cnt <= starve_cnt + SC_W'(1);
                    end
                end
                S_DMA: begin
                    if (dma_gnt) begin
                        // beat_cnt == BURST_MAX-1 means this grant is the final allowed beat.
                        if (dma_last_i || beat_cnt == LAST_BEAT) begin
                            state      <= S_CORE;
                            starve_cnt <= '0;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_CORE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_owner <= 1'b0;
        end else if (core_gnt || dma_gnt) begin
            rsp_owner <= dma_gnt;
        end
    end
`else
    logic unused_cfg;

    assign core_gnt   = core_req_i & rst_ni;
    assign dma_gnt    = 1'b0;
    assign rsp_owner  = 1'b0;
    assign unused_cfg = ^{dma_req_i, dma_last_i, 32'(STARVE_LIMIT), 32'(BURST_MAX)};
`endif

    // rsp_valid must also clear on idle cycles so a response lasts exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= (core_gnt & ~core_we_i) | (dma_gnt & ~dma_we_i);
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (dma_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = {4{dma_we_i}} & dma_be_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
        end else if (core_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = {4{core_we_i}} & core_be_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign core_stall_o  = rst_ni & core_req_i & ~core_gnt;
    assign dma_gnt_o     = dma_gnt;
    assign core_rvalid_o = rsp_valid & ~rsp_owner;
    assign dma_rvalid_o  = rsp_valid & rsp_owner;
    assign core_rdata_o  = (rsp_valid && !rsp_owner) ? mem_rdata_i : 32'h0;
    assign dma_rdata_o   = (rsp_valid && rsp_owner) ? mem_rdata_i : 32'h0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the core's 4-bank byte-wide data memory (32-bit word, 13-bit word address, per-byte write enables). It shares the memory between the pipeline's MEM-stage load/store port and a DMA/loader port. DMA gets burst locking, the core is protected by a starvation counter, and read responses are routed back to the requester that issued them. The block sits between the MEM stage and the block-RAM banks, and drives the pipeline stall when the core loses arbitration.

## Interface
- ADDR_W, 13, word address width (byte address bits [ADDR_W+1:2])
- STARVE_LIMIT, 4, consecutive core grants allowed while DMA waits (≥1)
- BURST_MAX, 8, maximum DMA beats per lock (≥1, power of 2 not required)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- core_req_i  in  1  core access request (level, held until granted)
- core_we_i  in  1  1=write, 0=read
- core_addr_i  in  ADDR_W  word address
- core_be_i  in  4  byte enables (writes only)
- core_wdata_i  in  32  write data, byte-lane aligned
- core_gnt_o  out  1  core access accepted this cycle
- core_stall_o  out  1  core_req_i & ~core_gnt_o
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  32  core read data
- dma_req_i, dma_we_i, dma_addr_i[ADDR_W-1:0], dma_be_i[3:0], dma_wdata_i[31:0]  in  DMA request fields, same meaning as the core fields
- dma_last_i  in  1  final beat of a DMA burst
- dma_gnt_o, dma_rvalid_o  out  1  DMA grant and read valid
- dma_rdata_o  out  32  DMA read data
- mem_en_o  out  1  bank enable (all four banks)
- mem_we_o  out  4  per-bank write enable
- mem_addr_o  out  ADDR_W  bank address
- mem_wdata_o  out  32  bank write data {b3,b2,b1,b0}
- mem_rdata_i  in  32  bank read data, valid 1 cycle after a read enable

## Operation
- FSM states: S_CORE (default, core preferred) and S_DMA (DMA locked).
- **S_CORE**
  - Core only → core granted.
  - DMA only → DMA granted.
  - Both requesting → core granted while starve_cnt < STARVE_LIMIT; otherwise DMA granted.
  - starve_cnt increments on every cycle dma_req_i is high and the core is granted. It clears whenever DMA is granted.
- **Entry to S_DMA:** a DMA grant in S_CORE without dma_last_i moves to S_DMA. beat_cnt is set to 1.
- **S_DMA**
  - DMA is granted whenever dma_req_i is high.
  - If dma_req_i is low, the core may be granted in that cycle (work-conserving). State and beat_cnt are unchanged.
  - Each DMA grant increments beat_cnt.
  - Return to S_CORE on a granted beat with dma_last_i, or when beat_cnt reaches BURST_MAX (forced release); starve_cnt clears.
- **Memory drive:** mem_* is a combinational mux of the granted requester's fields.
  - mem_en_o = any grant.
  - mem_we_o = {4{we}} & be.
  - No grant → mem_en_o=0, mem_we_o=0, address/data 0.
- **Read response**
  - rsp_valid/rsp_owner are registered on a granted read.
  - Next cycle: the owner's rvalid is 1 and its rdata = mem_rdata_i. The other port's rdata = 0.
  - Writes produce no rvalid.
- **Reset:** asynchronous, active-low. It forces S_CORE, clears starve_cnt, beat_cnt and rsp_valid, and all outputs go to 0. A read in flight at reset is dropped and no rvalid is issued after reset.

## Timing
- Grant is combinational from the requests and registered state: zero-cycle arbitration.
- A request and its grant share a cycle.
- Read latency: exactly 1 cycle from grant to rvalid.
- Back-to-back grants are legal every cycle on either port. Responses never collide, because only one grant is issued per cycle.
- Requesters hold all fields stable while req is high and gnt is low.
- State, counters and response tag update on the rising edge only when the corresponding grant is asserted.

## Configuration
- DMEM_ARB_DMA_EN
  - Defined: full two-port behaviour as above.
  - Undefined:
    - DMA inputs are ignored.
    - dma_gnt_o, dma_rvalid_o and dma_rdata_o are tied 0.
    - The FSM and counters are removed.
    - core_gnt_o = core_req_i, core_stall_o = 0.
    - Response routing is to the core only.

## Test plan
- **Core-only read after write:** core writes addr 0x010, be=0xF, 0xDEADBEEF, then reads 0x010. Required: mem_we_o=0xF on the write, and core_rvalid_o=1 with core_rdata_o=0xDEADBEEF one cycle after the read grant.
- **Starvation limit:** core and DMA request continuously, STARVE_LIMIT=4. Required: core granted cycles 0–3, DMA granted in cycle 4, core_stall_o=1 in cycle 4.
- **Burst lock:** DMA issues a 3-beat burst (dma_last_i on beat 3) while the core requests. Required: the core is stalled for 3 cycles, then granted in the next cycle. State returns to S_CORE.
- **Forced release:** BURST_MAX=8 and DMA never asserts dma_last_i. Required: after 8 DMA grants the FSM is in S_CORE and the pending core request is granted.
- **Bubble fill and response routing:** in S_DMA, dma_req_i drops for 1 cycle while the core reads 0x020 (containing 0x12345678). Required: core granted in that cycle, core_rvalid_o=1 with 0x12345678 next cycle, dma_rvalid_o=0, and the DMA lock is retained.
- **Reset mid-read:** assert rst_ni=0 in the cycle after a DMA read grant. Required: all outputs 0 immediately, and no dma_rvalid_o after rst_ni returns to 1.
